// File: rtl/nco_pkg.sv
// ----------------------------------------------------------------------------
// nco_pkg : shared config struct, widths and rounding-constant helper for the NCO
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package nco_pkg;

  localparam int NCO_PWIDTH = 32;

  typedef struct packed {
    logic [NCO_PWIDTH-1:0] freq;
    logic [NCO_PWIDTH-1:0] poff0;
    logic [NCO_PWIDTH-1:0] poff1;
    logic                  mode0;
    logic                  mode1;
  } nco_cfg_t;

  // Half an output LSB, so a plain truncation of (value + constant) rounds half-up.
  function automatic logic [NCO_PWIDTH-1:0] round_const(input int pwidth, input int width,
                                                         input bit round_en);
    logic [NCO_PWIDTH-1:0] one;
    one = {{(NCO_PWIDTH-1){1'b0}}, 1'b1};
    return round_en ? (one << (pwidth - width - 1)) : '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clkena_delay_line.sv
// ----------------------------------------------------------------------------
// clkena_delay_line : DEPTH-stage shift register advancing only on clkena
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module clkena_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clkena,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH*DEPTH-1:0] pipe_q;
  logic [WIDTH*DEPTH-1:0] pipe_d;

  generate
    if (DEPTH == 1) begin : g_single
      always_comb begin
        pipe_d = clkena ? din : pipe_q;
      end
    end else begin : g_chain
      always_comb begin
        pipe_d = clkena ? {pipe_q[WIDTH*(DEPTH-1)-1:0], din} : pipe_q;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pipe_q <= '0;
    else       pipe_q <= pipe_d;
  end

  assign dout = pipe_q[WIDTH*DEPTH-1 -: WIDTH];

endmodule

`default_nettype wire

// File: rtl/nco_phase_acc.sv
// ----------------------------------------------------------------------------
// nco_phase_acc : phase accumulator with shadowed config, two offset phase args
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module nco_phase_acc
  import nco_pkg::*;
#(
  parameter int PWIDTH  = NCO_PWIDTH,
  parameter int WIDTH   = 16,
  parameter int ROUND   = 0,
  parameter int ROM_LAT = 4
) (
  input  logic              reset,
  input  logic              clk,
  input  logic              clkena,
  input  logic [PWIDTH-1:0] freq,
  input  logic [PWIDTH-1:0] poff0,
  input  logic [PWIDTH-1:0] poff1,
  input  logic              cfg_mode0,
  input  logic              cfg_mode1,
  input  logic              cfg_load,
  input  logic              cfg_apply,
  input  logic              sync_clr,
  output logic [WIDTH-1:0]  arg0,
  output logic [WIDTH-1:0]  arg1,
  output logic              mode0,
  output logic              mode1,
  output logic              wrap,
  output logic              func_valid
);

  localparam logic [PWIDTH-1:0] RND_C = round_const(PWIDTH, WIDTH, ROUND != 0);

  nco_cfg_t          cfg_in;
  nco_cfg_t          shadow_q, shadow_d;
  nco_cfg_t          active_q, active_d;
  logic              apply_pend_q, apply_pend_d;
  logic              apply_now;
  logic [PWIDTH-1:0] acc_q, acc_d;
  logic [PWIDTH:0]   acc_sum;
  logic [PWIDTH-1:0] sum0, sum1;
  logic [WIDTH-1:0]  arg0_q, arg0_d, arg1_q, arg1_d;
  logic              mode0_q, mode0_d, mode1_q, mode1_d;
  logic              wrap_q, wrap_d;

  always_comb begin
    cfg_in = '{freq: freq, poff0: poff0, poff1: poff1, mode0: cfg_mode0, mode1: cfg_mode1};

    // Shadow capture ignores the stall; an apply in the same cycle sees the
    // freshly loaded inputs because active is fed from shadow_d.
    shadow_d     = cfg_load ? cfg_in : shadow_q;
    apply_now    = clkena && (apply_pend_q || cfg_apply);
    active_d     = apply_now ? shadow_d : active_q;
    apply_pend_d = apply_now ? 1'b0 : (apply_pend_q || cfg_apply);

    acc_sum = {1'b0, acc_q} + {1'b0, active_q.freq};
    sum0    = acc_q + active_q.poff0 + RND_C;
    sum1    = acc_q + active_q.poff1 + RND_C;

    acc_d   = acc_q;
    arg0_d  = arg0_q;
    arg1_d  = arg1_q;
    mode0_d = mode0_q;
    mode1_d = mode1_q;
    wrap_d  = wrap_q;

    if (clkena) begin
      arg0_d  = sum0[PWIDTH-1 -: WIDTH];
      arg1_d  = sum1[PWIDTH-1 -: WIDTH];
      mode0_d = active_q.mode0;
      mode1_d = active_q.mode1;
      wrap_d  = sync_clr ? 1'b0 : acc_sum[PWIDTH];
      acc_d   = sync_clr ? '0 : acc_sum[PWIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q     <= '0;
      active_q     <= '0;
      apply_pend_q <= 1'b0;
      acc_q        <= '0;
      arg0_q       <= '0;
      arg1_q       <= '0;
      mode0_q      <= 1'b0;
      mode1_q      <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      apply_pend_q <= apply_pend_d;
      acc_q        <= acc_d;
      arg0_q       <= arg0_d;
      arg1_q       <= arg1_d;
      mode0_q      <= mode0_d;
      mode1_q      <= mode1_d;
      wrap_q       <= wrap_d;
    end
  end

  // One stage for the arg register plus ROM_LAT stages matching the ROM.
  clkena_delay_line #(
    .WIDTH (1),
    .DEPTH (1 + ROM_LAT)
  ) u_valid_pipe (
    .clk    (clk),
    .reset  (reset),
    .clkena (clkena),
    .din    (1'b1),
    .dout   (func_valid)
  );

  assign arg0  = arg0_q;
  assign arg1  = arg1_q;
  assign mode0 = mode0_q;
  assign mode1 = mode1_q;
  assign wrap  = wrap_q;

endmodule

`default_nettype wire

// File: doc/nco_phase_acc.md
# nco_phase_acc

Numerically-controlled phase generator feeding the two-argument sin/cos ROM stage. It accumulates a programmable frequency word and produces two phase arguments with independent phase offsets and mode bits. It also produces a valid flag aligned to the ROM output. It shares the ROM stage's `clkena` stall domain: one `clkena` cycle is one sample step.

## Interface
- `PWIDTH`, 32: accumulator / frequency / offset width.
- `WIDTH`, 16: output argument width, equal to the ROM stage `WIDTH`. Constraint: `PWIDTH >= WIDTH + 1`.
- `ROUND`, 0: 1 means round-half-up when truncating to `WIDTH`; 0 means plain truncation.
- `ROM_LAT`, 4: latency of the downstream ROM stage, in `clkena` cycles.
- `reset`  in  1: reset, asynchronous, active-high.
- `clk`  in  1: clock `clk`.
- `clkena`  in  1: sample step / stall. When low, all state holds.
- `freq`  in  PWIDTH: frequency word, captured by `cfg_load`.
- `poff0`, `poff1`  in  PWIDTH: phase offsets, captured by `cfg_load`.
- `cfg_mode0`, `cfg_mode1`  in  1: 0 = sin, 1 = cos; captured by `cfg_load`.
- `cfg_load`  in  1: capture config inputs into shadow registers. Independent of `clkena`.
- `cfg_apply`  in  1: request shadow→active transfer.
- `sync_clr`  in  1: clear accumulator phase.
- `arg0`, `arg1`  out  WIDTH: phase arguments for the ROM.
- `mode0`, `mode1`  out  1: mode bits, aligned with `arg0` / `arg1`.
- `wrap`  out  1: accumulator overflow flag for the current step.
- `func_valid`  out  1: ROM `func0`/`func1` hold valid data.

## Operation
- **State:** accumulator `acc`; shadow and active copies of `freq`, `poff0`, `poff1`, mode bits; `apply_pend` flag; valid shift register.
- **Reset values:** every register is 0, including all outputs, `acc`, shadow/active config and `apply_pend`.
- **Shadow capture:** `cfg_load=1` captures inputs into shadow on any clk edge.
- **Apply request:** `cfg_apply=1` sets `apply_pend`.
- **Apply execution:** on a `clkena` cycle with `apply_pend` set (or `cfg_apply` high that cycle), active ← shadow and `apply_pend` clears.
- **Load and apply in the same cycle:** active takes the *input* values (bypass), not the stale shadow.
- **Apply timing:** the active update is visible from the next step. Outputs and `acc` in the apply cycle use the old active values.
- **Step computation** (each `clkena=1` cycle; all sums modulo 2^PWIDTH):
  - `sK = acc + poffK_act`.
  - With `ROUND=1`, add 2^(PWIDTH−WIDTH−1) modulo 2^PWIDTH before truncation.
  - `argK ← sK[PWIDTH−1 : PWIDTH−WIDTH]`.
  - `modeK ← cfg_modeK_act`.
  - `wrap ←` carry-out of `acc + freq_act`.
  - `acc ← sync_clr ? 0 : acc + freq_act`.
- **`sync_clr` semantics:** `arg` in the clear cycle still reflects the old `acc`. The next step outputs `poffK` only. `wrap` is forced to 0 in a clear cycle.
- **Simultaneous `sync_clr` and apply:** `acc` → 0, new config takes effect from the next step (the next `acc` increment uses the new `freq`).
- **Valid pipeline:** a 1+`ROM_LAT`-bit shift register shifts in 1 on each `clkena` cycle. `func_valid` = MSB. Only `reset` clears it; `sync_clr` and config changes do not.
- **Clock enable low:** all registers except shadow capture and `apply_pend` hold, including `wrap` and `func_valid`. Consumers qualify `wrap` with `clkena`.

## Timing
- **`arg`/`mode` latency:** registered outputs, 1 `clkena` cycle after `acc`.
- **`func_valid`:** rises on the clk edge ending the (1+`ROM_LAT`)-th `clkena` cycle after reset release. This aligns with the first ROM result derived from a post-reset `arg`.
- **Reset mid-operation:** asynchronous clear of everything. Shadow config is lost and must be reloaded.
- **Stalls:** `cfg_apply` pulses during `clkena=0` are remembered by `apply_pend`; repeated pulses collapse to one.

## Structure
- **Package `nco_pkg`:**
  - `nco_cfg_t` packed struct (`freq`, `poff0`, `poff1`, `mode0`, `mode1`), parameterised through localparam widths.
  - Rounding-constant function.
- **One sub-module, `clkena_delay_line`:** `WIDTH`/`DEPTH`-parameterised shift register gated by `clkena`, async-reset to 0. Used for the valid pipe; reusable for sideband data alongside the ROM.

## Test plan
- **Basic ramp:** `PWIDTH=32`, `WIDTH=16`, `ROUND=0`, `freq=0x0100_0000`, offsets 0, apply, `clkena=1` continuously.
  - `arg0` steps 0x0000, 0x0100, 0x0200…
  - `wrap`=1 exactly once per 256 steps, in the step where `acc`=0xFF00_0000.
- **Quadrature offset:** `poff1=0x4000_0000`, `mode1=0` → `arg1 = arg0 + 0x4000` mod 2^16 every step. `mode0`/`mode1` outputs match the config.
- **Rounding:** `ROUND=1`, `freq=0x0000_8000`, offsets 0.
  - `arg0` = 0,1,1,2,2,… (0x8000 rounds up from step 1).
  - `poff0=0xFFFF_8000` with `acc`=0 → `arg0`=0x0000 (wraps).
- **Stall and `func_valid`:** toggle `clkena` 1,0,1,0… after reset.
  - `func_valid` rises after the 5th `clkena`-high cycle.
  - `arg` and `wrap` hold during low cycles.
  - A `cfg_apply` pulse during a low cycle takes effect at the next high cycle.
- **Sync clear and apply:** at `acc`=0x1234_0000, assert `sync_clr` and `cfg_apply` together with new `freq=0x0200_0000`.
  - Same-cycle `arg0`=0x1234.
  - Next step `arg0`=`poff0[31:16]`.
  - Following step advances by 0x0200.
- **Load/apply bypass and reset:** `cfg_load` and `cfg_apply` in the same `clkena` cycle → new `freq` used from the next step. Mid-run `reset` pulse → all outputs 0 and `func_valid` 0 immediately.
